uart_frame_writer: RTL and testbench
====================================

// Module: uart_frame_writer
// PURPOSE
//   Write side of the frame buffer in vga_serial_display: takes the byte stream from the
//   UART receiver (R,G,B order, 8 bits per channel), assembles 24-bit RGB888 pixels and
//   writes them to sequential frame-buffer addresses. The VGA read path (dithering, 8->4 bit)
//   consumes these words. Resynchronises on inter-byte timeout or on an explicit restart.
// PARAMETERS
//   N_PIXELS        19200      pixels per frame (160x120); address wraps after N_PIXELS-1
//   ADDR_WIDTH      15         frame-buffer address width; 2**ADDR_WIDTH >= N_PIXELS
//   TIMEOUT_CYCLES  1_000_000  idle cycles with a partial pixel before it is discarded
// PORTS
//   clk         in   1           system clock
//   rst         in   1           asynchronous reset, active high
//   rx_data     in   8           byte from UART receiver
//   rx_ready    in   1           1-cycle strobe: rx_data valid
//   restart     in   1           sync: drop partial pixel, address back to 0
//   fb_we       out  1           frame-buffer write enable (1-cycle pulse)
//   fb_addr     out  ADDR_WIDTH  write address
//   fb_wdata    out  24          {R,G,B}
//   frame_done  out  1           1-cycle pulse coincident with write of pixel N_PIXELS-1
//   busy        out  1           1 while a partial pixel (1 or 2 bytes) is held
//   timeout_err out  1           1-cycle pulse when a partial pixel is discarded by timeout
// BEHAVIOUR
//   Reset (async, rst=1): all outputs 0; ch_idx=0, addr=0, timeout counter=0, R/G regs=0.
//   Byte capture: on rx_ready, ch_idx 0->R reg, 1->G reg, 2->B; ch_idx increments 0,1,2,0.
//   Write: cycle after the rx_ready carrying B: fb_we=1, fb_wdata={R,G,B}, fb_addr=current
//     addr. Latency 1 cycle from third strobe. fb_addr/fb_wdata held stable until next write.
//   Address: increments by 1 in the cycle after fb_we; at fb_we with addr==N_PIXELS-1,
//     frame_done=1 in the same cycle, next addr=0. No stall: writer never back-pressures.
//   Back-to-back: rx_ready in the same cycle as fb_we is captured normally (as R of next pixel).
//   busy = (ch_idx != 0).
//   Timeout: counter clears on every rx_ready and when ch_idx==0; counts while ch_idx!=0.
//     When it reaches TIMEOUT_CYCLES-1: ch_idx->0, timeout_err pulses 1 cycle, addr unchanged,
//     no write. rx_ready in the timeout cycle wins: byte accepted, no timeout_err.
//   restart: next cycle ch_idx=0, addr=0, timeout counter=0. restart with rx_ready: restart
//     wins, byte dropped. restart in the fb_we cycle: write completes, then addr=0 (not +1);
//     frame_done unaffected.
//   Reset mid-pixel: partial pixel lost, outputs go 0 immediately (asynchronous).
//   Widths: counters sized $clog2(TIMEOUT_CYCLES); no arithmetic on pixel data.
// TESTING
//   rst, then bytes 0x12,0x34,0x56 -> fb_we one cycle after 3rd strobe, addr 0, wdata 0x123456.
//   3*N_PIXELS bytes, strobes 10 cycles apart -> N_PIXELS writes, addr 0..N_PIXELS-1,
//     frame_done once on last write, next pixel written at addr 0.
//   Bytes 0xAA,0xBB then silence TIMEOUT_CYCLES -> timeout_err pulse, busy=0, no write;
//     then 0x01,0x02,0x03 -> wdata 0x010203 at unchanged addr.
//   Strobe coincident with fb_we (strobes every 1 cycle) -> no byte lost, wdata correct.
//   restart after 5 pixels and 1 byte -> next full pixel written at addr 0; restart with
//     rx_ready -> that byte dropped.
//   rst asserted mid-pixel (async, between clock edges) -> outputs 0 at once, addr 0 after.

Source files
------------

// File: rtl/uart_frame_writer_if.sv
// Byte-stream in / frame-buffer write out bundle for the UART frame writer.
// master = UART receiver side, slave = the writer itself.
interface uart_frame_writer_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  restart;
  logic                  fb_we;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [23:0]           fb_wdata;
  logic                  frame_done;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    output rx_data, rx_ready, restart,
    input  fb_we, fb_addr, fb_wdata, frame_done, busy, timeout_err
  );

  modport slave (
    input  rx_data, rx_ready, restart,
    output fb_we, fb_addr, fb_wdata, frame_done, busy, timeout_err
  );
endinterface

// File: rtl/uart_frame_writer.sv
// Assembles R,G,B bytes from the UART into RGB888 words and writes them to
// sequential frame-buffer addresses, resyncing on idle timeout or restart.
module uart_frame_writer #(
  parameter int N_PIXELS       = 19200,
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  uart_frame_writer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_PIXELS - 1);
  localparam logic [CW-1:0]         TO_MAX    = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_e;

  ch_e                   ch_q, ch_d;
  logic [7:0]            r_q, r_d, g_q, g_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fb_we_q, fb_we_d;
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic [23:0]           fb_wdata_q, fb_wdata_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timeout_err_q, timeout_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q          <= CH_R;
      r_q           <= '0;
      g_q           <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_wdata_q    <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ch_q          <= ch_d;
      r_q           <= r_d;
      g_q           <= g_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_wdata_q    <= fb_wdata_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    ch_d          = ch_q;
    r_d           = r_q;
    g_d           = g_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_wdata_d    = fb_wdata_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;

    // Address advances the cycle after a write; restart below may override it.
    if (fb_we_q) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

    if (bus.restart) begin
      ch_d   = CH_R;
      addr_d = '0;
      cnt_d  = '0;
    end else if (bus.rx_ready) begin
      cnt_d = '0;
      unique case (ch_q)
        CH_R: begin r_d = bus.rx_data; ch_d = CH_G; end
        CH_G: begin g_d = bus.rx_data; ch_d = CH_B; end
        CH_B: begin
          ch_d         = CH_R;
          fb_we_d      = 1'b1;
          fb_addr_d    = addr_q;
          fb_wdata_d   = {r_q, g_q, bus.rx_data};
          frame_done_d = (addr_q == LAST_ADDR);
        end
        default: ch_d = CH_R;
      endcase
    end else if (ch_q == CH_R) begin
      cnt_d = '0;
    end else if (cnt_q == TO_MAX) begin
      // Stale partial pixel: drop it, keep the address.
      ch_d          = CH_R;
      cnt_d         = '0;
      timeout_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign bus.fb_we       = fb_we_q;
  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_wdata    = fb_wdata_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = (ch_q != CH_R);
endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed/randomised bench for uart_frame_writer against a byte-queue pixel model.
module tb_uart_frame_writer;
  localparam int NP = 16;
  localparam int AW = 5;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_writer_if #(.ADDR_WIDTH(AW)) bus ();

  uart_frame_writer #(.N_PIXELS(NP), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int obs_done = 0;
  int m_addr = 0;
  logic [7:0] pbuf[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte strobe; the model decides whether a write must appear one cycle later.
  task automatic send(input logic [7:0] b, input int gap);
    logic [23:0] ed;
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
    if (bus.frame_done === 1'b1) obs_done++;
    pbuf.push_back(b);
    if (pbuf.size() == 3) begin
      ed = {pbuf[0], pbuf[1], pbuf[2]};
      chk("write_we", 32'(bus.fb_we), 1);
      chk("write_addr", 32'(bus.fb_addr), m_addr);
      chk("write_data", 32'(bus.fb_wdata), 32'(ed));
      chk("write_done", 32'(bus.frame_done), 32'(m_addr == NP - 1));
      m_addr = (m_addr + 1) % NP;
      pbuf.delete();
    end else begin
      chk("no_write", 32'(bus.fb_we), 0);
    end
    chk("busy", 32'(bus.busy), 32'(pbuf.size() != 0));
    repeat (gap) begin
      @(posedge clk); #1;
      chk("gap_we", 32'(bus.fb_we), 0);
      chk("gap_done", 32'(bus.frame_done), 0);
    end
  endtask

  task automatic restart_pulse(input logic with_byte, input logic [7:0] b);
    bus.restart  = 1'b1;
    bus.rx_ready = with_byte;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.restart  = 1'b0;
    bus.rx_ready = 1'b0;
    pbuf.delete();
    m_addr = 0;
    chk("restart_busy", 32'(bus.busy), 0);
    chk("restart_we", 32'(bus.fb_we), 0);
  endtask

  initial begin
    int d0;
    int n_to;
    bus.rx_data  = '0;
    bus.rx_ready = 1'b0;
    bus.restart  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_we", 32'(bus.fb_we), 0);
    chk("rst_addr", 32'(bus.fb_addr), 0);
    chk("rst_data", 32'(bus.fb_wdata), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_to", 32'(bus.timeout_err), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // First pixel
    send(8'h12, 2); send(8'h34, 2); send(8'h56, 3);

    // Full frame, strobes 10 cycles apart, then one more pixel at the wrapped address
    restart_pulse(1'b0, 8'h00);
    d0 = obs_done;
    for (int i = 0; i < 3 * NP; i++) send(8'($urandom), 9);
    chk("frame_done_count", obs_done - d0, 1);
    chk("wrap_model_addr", m_addr, 0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1);

    // Timeout discards a partial pixel
    send(8'hAA, 0); send(8'hBB, 0);
    n_to = -1;
    for (int n = 1; n <= TO + 5 && n_to < 0; n++) begin
      @(posedge clk); #1;
      chk("to_no_write", 32'(bus.fb_we), 0);
      if (bus.timeout_err === 1'b1) n_to = n;
    end
    chk("timeout_latency", n_to, TO);
    chk("timeout_busy", 32'(bus.busy), 0);
    pbuf.delete();
    @(posedge clk); #1;
    chk("timeout_pulse_len", 32'(bus.timeout_err), 0);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 2);

    // Back-to-back strobes, including strobe coincident with fb_we
    for (int i = 0; i < 12; i++) send(8'($urandom), 0);
    @(posedge clk); #1;

    // Restart after 5 pixels and 1 byte
    restart_pulse(1'b0, 8'h00);
    for (int i = 0; i < 15; i++) send(8'($urandom), int'($urandom_range(0, 3)));
    send(8'hC3, 2);
    restart_pulse(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1);
    // restart with rx_ready drops that byte
    send(8'h77, 1);
    restart_pulse(1'b1, 8'h99);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1);
    // restart in the fb_we cycle: write completes, address goes to 0
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
    restart_pulse(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);

    // Async reset mid-pixel
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    send(8'h5A, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.fb_we), 0);
    chk("arst_addr", 32'(bus.fb_addr), 0);
    chk("arst_data", 32'(bus.fb_wdata), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.frame_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pbuf.delete();
    m_addr = 0;
    for (int i = 0; i < 6; i++) send(8'($urandom), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
